// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor, Diff = A - B - Bin (unsigned, borrow out).
// One bit is processed per clock, LSB first, behind a start/busy/done handshake.
// The result is held stable until the next operation completes.
//
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset
//   start - request; accepted in IDLE or DONE
//   A, B  - minuend / subtrahend, latched on the accepting edge
//   Bin   - borrow in, latched on the accepting edge
//   Diff  - registered result (A - B - Bin) mod 2^WIDTH
//   Bout  - registered borrow out (1 iff A < B + Bin)
//   Ovf   - registered two's-complement overflow (only with SERIAL_SUB_OVF_EN)
//   busy  - high while bits are being processed
//   done  - one-cycle pulse when Diff/Bout are updated
//
// Optional feature macro: SERIAL_SUB_OVF_EN adds the Ovf output.
module serial_sub #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
`ifdef SERIAL_SUB_OVF_EN
  output logic             Ovf,
`endif
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             d_bit, br_next;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d   = ovf_q;
`endif

    // Full-subtractor cell on the current LSBs.
    d_bit   = a_q[0] ^ b_q[0] ^ br_q;
    br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          br_d    = Bin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = StShift;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        // start is deliberately ignored here.
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {d_bit, res_q[WIDTH-1:1]};
        br_d  = br_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          diff_d  = res_d;
          bout_d  = br_next;
`ifdef SERIAL_SUB_OVF_EN
          // Borrow into the MSB vs borrow out of the MSB.
          ovf_d   = br_q ^ br_next;
`endif
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StShift);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign Diff = diff_q;
  assign Bout = bout_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef SERIAL_SUB_OVF_EN
  assign Ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Directed self-checking bench for serial_sub at WIDTH=4.
module tb_serial_sub;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] a_in;
  logic [3:0] b_in;
  logic       bin_in;
  logic [3:0] diff;
  logic       bout;
  logic       busy;
  logic       done;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  int errors = 0;
  int checks = 0;

  serial_sub #(.WIDTH(4)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a_in),
    .B     (b_in),
    .Bin   (bin_in),
    .Diff  (diff),
    .Bout  (bout),
`ifdef SERIAL_SUB_OVF_EN
    .Ovf   (ovf),
`endif
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands at a negedge, hold start across one rising edge.
  // Returns at the negedge right after the accepting edge.
  task automatic launch(input logic [3:0] a, input logic [3:0] b, input logic bi);
    @(negedge clk);
    a_in   = a;
    b_in   = b;
    bin_in = bi;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Bounded wait for done; counts negedges advanced and busy samples seen.
  task automatic wait_done(output int cycles, output int busy_cnt);
    cycles   = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && cycles < 20) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({diff, bout, busy, done} !== 7'b0) begin
      errors++;
      $display("FAIL reset_async: got diff=%h bout=%b busy=%b done=%b, want all 0",
               diff, bout, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({diff, bout, busy, done} !== 7'b0) begin
      errors++;
      $display("FAIL reset_idle: got diff=%h bout=%b busy=%b done=%b, want all 0",
               diff, bout, busy, done);
    end
  endtask

  task automatic test_basic;
    int cyc, bc;
    launch(4'hA, 4'h5, 1'b0);
    wait_done(cyc, bc);
    checks++;
    if (cyc !== 4 || bc !== 4) begin
      errors++;
      $display("FAIL basic_latency: got cycles=%0d busy=%0d, want 4 and 4", cyc, bc);
    end
    checks++;
    if (diff !== 4'h5 || bout !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: got diff=%h bout=%b busy=%b, want 5 0 0", diff, bout, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || diff !== 4'h5) begin
      errors++;
      $display("FAIL basic_pulse: got done=%b diff=%h, want 0 5", done, diff);
    end
  endtask

  task automatic test_vectors;
    logic [3:0] va[3]  = '{4'hB, 4'h0, 4'h5};
    logic [3:0] vb[3]  = '{4'hC, 4'h0, 4'h5};
    logic       vi[3]  = '{1'b0, 1'b1, 1'b0};
    logic [3:0] ed[3]  = '{4'hF, 4'hF, 4'h0};
    logic       eb[3]  = '{1'b1, 1'b1, 1'b0};
    int cyc, bc;
    for (int i = 0; i < 3; i++) begin
      launch(va[i], vb[i], vi[i]);
      wait_done(cyc, bc);
      checks++;
      if (done !== 1'b1 || diff !== ed[i] || bout !== eb[i]) begin
        errors++;
        $display("FAIL vector%0d: got done=%b diff=%h bout=%b, want 1 %h %b",
                 i, done, diff, bout, ed[i], eb[i]);
      end
    end
  endtask

  task automatic test_start_ignored;
    int cyc, bc, extra;
    launch(4'h9, 4'h3, 1'b0);
    @(negedge clk);
    a_in   = 4'hF;
    b_in   = 4'hE;
    bin_in = 1'b1;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_done(cyc, bc);
    checks++;
    if (done !== 1'b1 || diff !== 4'h6 || bout !== 1'b0) begin
      errors++;
      $display("FAIL ignore_result: got done=%b diff=%h bout=%b, want 1 6 0", done, diff, bout);
    end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0 || diff !== 4'h6) begin
      errors++;
      $display("FAIL ignore_hold: got extra_activity=%0d diff=%h, want 0 6", extra, diff);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, bc;
    launch(4'hA, 4'h5, 1'b0);
    wait_done(cyc, bc);
    a_in   = 4'h2;
    b_in   = 4'h7;
    bin_in = 1'b0;
    start  = 1'b1;
    checks++;
    if (done !== 1'b1 || diff !== 4'h5 || bout !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: got done=%b diff=%h bout=%b, want 1 5 0", done, diff, bout);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || diff !== 4'h5) begin
      errors++;
      $display("FAIL b2b_restart: got done=%b busy=%b diff=%h, want 0 1 5", done, busy, diff);
    end
    wait_done(cyc, bc);
    checks++;
    if (cyc !== 4 || diff !== 4'hB || bout !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: got cycles=%0d diff=%h bout=%b, want 4 b 1", cyc, diff, bout);
    end
  endtask

  task automatic test_reset_abort;
    int cyc, bc, seen;
    launch(4'hA, 4'h5, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({diff, bout, busy, done} !== 7'b0) begin
      errors++;
      $display("FAIL abort_async: got diff=%h bout=%b busy=%b done=%b, want all 0",
               diff, bout, busy, done);
    end
    #1 rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0 || diff !== 4'h0) begin
      errors++;
      $display("FAIL abort_quiet: got activity=%0d diff=%h, want 0 0", seen, diff);
    end
    launch(4'h7, 4'h2, 1'b1);
    wait_done(cyc, bc);
    checks++;
    if (cyc !== 4 || bc !== 4 || diff !== 4'h4 || bout !== 1'b0) begin
      errors++;
      $display("FAIL abort_fresh: got cycles=%0d busy=%0d diff=%h bout=%b, want 4 4 4 0",
               cyc, bc, diff, bout);
    end
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf;
    logic [3:0] va[3] = '{4'h8, 4'h7, 4'h3};
    logic [3:0] vb[3] = '{4'h1, 4'hF, 4'h1};
    logic [3:0] ed[3] = '{4'h7, 4'h8, 4'h2};
    logic       eb[3] = '{1'b0, 1'b1, 1'b0};
    logic       eo[3] = '{1'b1, 1'b1, 1'b0};
    int cyc, bc;
    for (int i = 0; i < 3; i++) begin
      launch(va[i], vb[i], 1'b0);
      wait_done(cyc, bc);
      checks++;
      if (diff !== ed[i] || bout !== eb[i] || ovf !== eo[i]) begin
        errors++;
        $display("FAIL ovf%0d: got diff=%h bout=%b ovf=%b, want %h %b %b",
                 i, diff, bout, ovf, ed[i], eb[i], eo[i]);
      end
    end
  endtask
`endif

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    a_in   = '0;
    b_in   = '0;
    bin_in = 1'b0;
    test_reset();
    test_basic();
    test_vectors();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
